// File: rtl/freq_meas_ctrl.sv
// Frequency meter sequencer: filters the input, times one period in clock cycles,
// converts it to microseconds and two BCD display digits, and hands results over valid/ack.
module freq_meas_ctrl #(
    parameter int CNT_W      = 20,
    parameter int CLK_PER_US = 10,
    parameter int FILT       = 6,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        signal_i,
    input  logic        ack_i,
    output logic        valid_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] period_us_o,
    output logic [3:0]  digit_hi_o,
    output logic [3:0]  digit_lo_o,
    output logic        dp_pos_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT1, S_MEAS, S_DIV, S_BCD, S_PRESENT
    } state_t;

    localparam int                STEP_W = $clog2(CNT_W);
    localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]    DIVR_C = (CNT_W+1)'(CLK_PER_US);
    localparam logic [STEP_W-1:0] LAST_C = STEP_W'(CNT_W - 1);

    state_t state_q, state_d;

    logic [1:0]        sync_q;
    logic [FILT-1:0]   hist_q;
    logic              edge_w;

    logic [CNT_W-1:0]  cnt_q, quo_q, rem_q, quo_nx;
    logic [CNT_W:0]    trial_w;
    logic              ge_w;
    logic [STEP_W-1:0] step_q;
    logic [15:0]       per_nx, per_q, bin_q, sub_w;
    logic [1:0]        ph_q;
    logic              bcd_ge_w, bcd_done_w, res_load_w;
    logic [3:0]        th_q, hu_q, te_q;

    logic              valid_q, tmo_q, dp_q;
    logic [15:0]       period_q;
    logic [3:0]        dhi_q, dlo_q;

    // An edge counts only after FILT clean low samples, so short low glitches are rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[0], signal_i};
            hist_q <= {hist_q[FILT-2:0], sync_q[1]};
        end
    end

    assign edge_w = sync_q[1] & ~(|hist_q);

    // Restoring divider step: remainder stays below the divisor, so CNT_W bits suffice.
    assign trial_w = {rem_q, quo_q[CNT_W-1]};
    assign ge_w    = (trial_w >= DIVR_C);
    assign quo_nx  = {quo_q[CNT_W-2:0], ge_w};
    assign per_nx  = (|quo_nx[CNT_W-1:16]) ? 16'hFFFF : quo_nx[15:0];

    always_comb begin
        sub_w = 16'd10;
        case (ph_q)
            2'd0:    sub_w = 16'd1000;
            2'd1:    sub_w = 16'd100;
            default: sub_w = 16'd10;
        endcase
    end

    assign bcd_ge_w   = (bin_q >= sub_w);
    assign bcd_done_w = (ph_q == 2'd2) && !bcd_ge_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_ARM;
            S_ARM:     state_d = S_WAIT1;
            S_WAIT1: begin
                if (edge_w)              state_d = S_MEAS;
                else if (cnt_q == TMO_C) state_d = S_PRESENT;
            end
            S_MEAS: begin
                if (edge_w)              state_d = S_DIV;
                else if (cnt_q == TMO_C) state_d = S_PRESENT;
            end
            S_DIV:     if (step_q == LAST_C) state_d = S_BCD;
            S_BCD:     if (bcd_done_w)       state_d = S_PRESENT;
            S_PRESENT: if (ack_i)            state_d = S_ARM;
            default:   state_d = S_IDLE;
        endcase
        if (!enable_i) state_d = S_IDLE;
    end

    assign res_load_w = (state_d == S_PRESENT) && (state_q != S_PRESENT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            step_q   <= '0;
            per_q    <= '0;
            bin_q    <= '0;
            ph_q     <= '0;
            th_q     <= '0;
            hu_q     <= '0;
            te_q     <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            period_q <= '0;
            dhi_q    <= 4'hF;
            dlo_q    <= 4'hF;
            dp_q     <= 1'b0;
        end else begin
            valid_q <= (state_d == S_PRESENT);
            case (state_q)
                S_ARM:   cnt_q <= '0;
                S_WAIT1: cnt_q <= edge_w ? CNT_W'(1) : cnt_q + CNT_W'(1);
                S_MEAS: begin
                    if (edge_w) begin
                        quo_q  <= cnt_q;
                        rem_q  <= '0;
                        step_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    rem_q  <= CNT_W'(ge_w ? trial_w - DIVR_C : trial_w);
                    quo_q  <= quo_nx;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == LAST_C) begin
                        per_q <= per_nx;
                        bin_q <= per_nx;
                        ph_q  <= '0;
                        th_q  <= '0;
                        hu_q  <= '0;
                        te_q  <= '0;
                    end
                end
                S_BCD: begin
                    if (bcd_ge_w) begin
                        bin_q <= bin_q - sub_w;
                        case (ph_q)
                            2'd0:    th_q <= th_q + 4'd1;
                            2'd1:    hu_q <= hu_q + 4'd1;
                            default: te_q <= te_q + 4'd1;
                        endcase
                    end else if (!bcd_done_w) begin
                        ph_q <= ph_q + 2'd1;
                    end
                end
                default: ;
            endcase

            // Result registers change only on entry to PRESENT, all in the same cycle.
            if (res_load_w) begin
                if (state_q == S_BCD) begin
                    tmo_q    <= 1'b0;
                    period_q <= per_q;
                    if (per_q < 16'd1000) begin
                        dhi_q <= hu_q;
                        dlo_q <= te_q;
                        dp_q  <= 1'b0;
                    end else begin
                        dhi_q <= th_q;
                        dlo_q <= hu_q;
                        dp_q  <= 1'b1;
                    end
                end else begin
                    tmo_q    <= 1'b1;
                    period_q <= 16'hFFFF;
                    dhi_q    <= 4'hF;
                    dlo_q    <= 4'hF;
                    dp_q     <= 1'b0;
                end
            end
        end
    end

    assign valid_o     = valid_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_PRESENT);
    assign timeout_o   = tmo_q;
    assign period_us_o = period_q;
    assign digit_hi_o  = dhi_q;
    assign digit_lo_o  = dlo_q;
    assign dp_pos_o    = dp_q;

endmodule
